nivel_corriente_ctrl: RTL and testbench

NIVEL_CORRIENTE_CTRL -- requirements
Module: nivel_corriente_ctrl

---
 rtl/nivel_corriente_ctrl_pkg.sv | 32 +++
 rtl/nivel_corriente_ctrl_debounce.sv | 79 +++++++
 rtl/nivel_corriente_ctrl.sv | 119 +++++++++++
 tb/tb_nivel_corriente_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nivel_corriente_ctrl_pkg.sv
// Shared definitions for the current-level controller: level limits, debounce
// state encoding and the active-low digit-enable patterns.
package nivel_corriente_ctrl_pkg;

  localparam int LEVEL_MAX = 10;
  localparam int LEVEL_W   = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  localparam logic [3:0] AN_SLOT0 = 4'b1110;
  localparam logic [3:0] AN_SLOT1 = 4'b1101;
  localparam logic [3:0] AN_SLOT2 = 4'b1011;
  localparam logic [3:0] AN_SLOT3 = 4'b0111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
    logic [3:0] an;
    case (slot)
      2'd0:    an = AN_SLOT0;
      2'd1:    an = AN_SLOT1;
      2'd2:    an = AN_SLOT2;
      default: an = AN_SLOT3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/nivel_corriente_ctrl_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer followed by a four-state debounce
// FSM; emits a one-cycle press pulse on a debounced low-to-high change only.
module debounce_btn
  import nivel_corriente_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_ff1, sync_ff2;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= btn;
      sync_ff2 <= sync_ff1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds how many consecutive differing samples have been seen,
  // including the one that left the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: if (sync_ff2) begin
        if (DEB_CYCLES <= 1) state_d = STABLE_HI;
        else begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync_ff2)              state_d = STABLE_LO;
        else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      STABLE_HI: if (!sync_ff2) begin
        if (DEB_CYCLES <= 1) state_d = STABLE_LO;
        else begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync_ff2)               state_d = STABLE_HI;
        else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = STABLE_LO;
    endcase
  end

  always_comb begin
    press = (state_q == STABLE_LO || state_q == WAIT_HI) && (state_d == STABLE_HI);
  end

endmodule

// File: rtl/nivel_corriente_ctrl.sv
// Current-level controller: two debounced buttons set a 0..10 level that drives
// a glitch-free PWM and a 4-digit multiplexed display. Optional BLANK_ZEROS_EN.
module nivel_corriente_ctrl
  import nivel_corriente_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 250000,
  parameter int PWM_PERIOD  = 100,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  output logic [3:0] indicadorCoriente,
  output logic       pwm_out,
  output logic [3:0] an_n,
  output logic [3:0] digito_bcd
);

  localparam int PWM_W    = $clog2(PWM_PERIOD);
  localparam int DUTY_W   = PWM_W + 1;
  localparam int PWM_STEP = PWM_PERIOD / 10;
  localparam int SCAN_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(LEVEL_MAX);
  localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic               press_up, press_dn;
  logic [LEVEL_W-1:0] level_q;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [DUTY_W-1:0]  duty_shadow, duty_new, duty_eff;
  logic [SCAN_W-1:0]  scan_tmr;
  logic               scan_wrap;
  logic [1:0]         slot_q, slot_nxt;
  logic [3:0]         an_nxt, dig_nxt;

  debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_up),
    .press   (press_up)
  );

  debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_down),
    .press   (press_dn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
    end else if (press_up && !press_dn) begin
      if (level_q != LEVEL_TOP) level_q <= level_q + 1'b1;
    end else if (press_dn && !press_up) begin
      if (level_q != '0) level_q <= level_q - 1'b1;
    end
  end

  assign indicadorCoriente = level_q;

  // At count 0 the freshly loaded duty is used directly so every period is
  // generated from a single duty value.
  assign duty_new = DUTY_W'(level_q) * DUTY_W'(PWM_STEP);
  assign duty_eff = (pwm_cnt == '0) ? duty_new : duty_shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt     <= '0;
      duty_shadow <= '0;
      pwm_out     <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      if (pwm_cnt == '0) duty_shadow <= duty_new;
      pwm_out <= ({1'b0, pwm_cnt} < duty_eff);
    end
  end

  assign scan_wrap = (scan_tmr == SCAN_LAST);
  assign slot_nxt  = slot_q + 2'd1;

  always_comb begin
    an_nxt  = an_for_slot(slot_nxt);
    dig_nxt = dig0;
    case (slot_nxt)
      2'd0:    dig_nxt = dig0;
      2'd1:    dig_nxt = dig1;
      2'd2:    dig_nxt = dig2;
      default: dig_nxt = dig3;
    endcase
`ifdef BLANK_ZEROS_EN
    if (slot_nxt == 2'd3 && dig3 == 4'd0) an_nxt = AN_OFF;
`endif
  end

  // Digits are captured only when their slot becomes active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_tmr   <= '0;
      slot_q     <= 2'd3;
      an_n       <= AN_OFF;
      digito_bcd <= '0;
    end else begin
      scan_tmr <= scan_wrap ? '0 : scan_tmr + 1'b1;
      if (scan_wrap) begin
        slot_q     <= slot_nxt;
        an_n       <= an_nxt;
        digito_bcd <= dig_nxt;
      end
    end
  end

endmodule

// File: tb/tb_nivel_corriente_ctrl.sv
// Self-checking bench for nivel_corriente_ctrl with small timing parameters.
// Honours BLANK_ZEROS_EN when the design is built with it.
module tb_nivel_corriente_ctrl;

  localparam int DEB_CYCLES  = 4;
  localparam int PWM_PERIOD  = 20;
  localparam int SCAN_CYCLES = 3;
  localparam int PRESS_LEN   = 12;
  localparam int PRESS_HIGH  = 6;
  localparam int LEVEL_TOP   = 10;

  logic       clk = 1'b0;
  logic       reset_n, btn_up, btn_down;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [3:0] indicadorCoriente, an_n, digito_bcd;
  logic       pwm_out;
  logic [12:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         n, m_level, m_duty_lvl, slot;
  logic       e_pwm;
  logic [3:0] e_an, e_dig;
  logic       s1[2], s2[2], db[2];
  int         run[2];

  nivel_corriente_ctrl #(
    .DEB_CYCLES  (DEB_CYCLES),
    .PWM_PERIOD  (PWM_PERIOD),
    .SCAN_CYCLES (SCAN_CYCLES)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .dig3              (dig3),
    .dig2              (dig2),
    .dig1              (dig1),
    .dig0              (dig0),
    .indicadorCoriente (indicadorCoriente),
    .pwm_out           (pwm_out),
    .an_n              (an_n),
    .digito_bcd        (digito_bcd)
  );

  always #5 clk = ~clk;

  assign dut_vec = {indicadorCoriente, pwm_out, an_n, digito_bcd};

  function automatic logic [12:0] exp_vec();
    return {4'(m_level), e_pwm, e_an, e_dig};
  endfunction

  task automatic model_reset();
    n = 0; m_level = 0; m_duty_lvl = 0; slot = 3;
    e_pwm = 1'b0; e_an = 4'hF; e_dig = 4'h0;
    for (int b = 0; b < 2; b++) begin
      s1[b] = 1'b0; s2[b] = 1'b0; db[b] = 1'b0; run[b] = 0;
    end
  endtask

  // One clock edge of the behavioural model, evaluated from the inputs at the edge.
  task automatic model_edge();
    int         j;
    logic       raw[2];
    logic       pr[2];
    logic [3:0] digs[4];
    j = n % PWM_PERIOD;
    if (j == 0) m_duty_lvl = m_level;
    e_pwm = (j < m_duty_lvl * (PWM_PERIOD / 10));
    if (n % SCAN_CYCLES == SCAN_CYCLES - 1) begin
      slot  = (slot + 1) % 4;
      digs  = '{dig0, dig1, dig2, dig3};
      e_dig = digs[slot];
      e_an  = ~(4'b0001 << slot);
`ifdef BLANK_ZEROS_EN
      if (slot == 3 && dig3 == 4'd0) e_an = 4'hF;
`endif
    end
    raw = '{btn_up, btn_down};
    for (int b = 0; b < 2; b++) begin
      pr[b] = 1'b0;
      if (s2[b] !== db[b]) begin
        run[b]++;
        if (run[b] == DEB_CYCLES) begin
          db[b]  = s2[b];
          run[b] = 0;
          pr[b]  = db[b];
        end
      end else begin
        run[b] = 0;
      end
    end
    if (pr[0] && !pr[1] && m_level < LEVEL_TOP) m_level++;
    else if (pr[1] && !pr[0] && m_level > 0) m_level--;
    for (int b = 0; b < 2; b++) begin
      s2[b] = s1[b];
      s1[b] = raw[b];
    end
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd0;
    #1 reset_n = 1'b0;
    #2;
    total++; if (indicadorCoriente !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", indicadorCoriente); end
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an_n); end
    total++; if (digito_bcd !== 4'd0) begin bad++; $display("FAIL reset_dig got=%0d exp=0", digito_bcd); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_bounce();
    int changes;
    logic [3:0] prev;
    changes = 0;
    prev = indicadorCoriente;
    for (int c = 0; c < 23; c++) begin
      btn_up = (c == 1) ? 1'b0 : (c < 13);
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL bounce cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (indicadorCoriente !== prev) changes++;
      prev = indicadorCoriente;
    end
    total++; if (changes !== 1) begin bad++; $display("FAIL bounce_changes got=%0d exp=1", changes); end
    total++; if (indicadorCoriente !== 4'd1) begin bad++; $display("FAIL bounce_level got=%0d exp=1", indicadorCoriente); end
  endtask

  task automatic test_saturation();
    int ones;
    for (int c = 0; c < 12 * PRESS_LEN; c++) begin
      btn_up = (c % PRESS_LEN) < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL sat_up cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd10) begin bad++; $display("FAIL sat_top got=%0d exp=10", indicadorCoriente); end
    ones = 0;
    for (int c = 0; c < 2 * PWM_PERIOD; c++) begin
      tick();
      if (pwm_out === 1'b1) ones++;
    end
    total++; if (ones !== 2 * PWM_PERIOD) begin bad++; $display("FAIL sat_pwm_full got=%0d exp=%0d", ones, 2 * PWM_PERIOD); end
    for (int c = 0; c < 12 * PRESS_LEN; c++) begin
      btn_down = (c % PRESS_LEN) < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL sat_down cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd0) begin bad++; $display("FAIL sat_bottom got=%0d exp=0", indicadorCoriente); end
    ones = 0;
    for (int c = 0; c < 2 * PWM_PERIOD; c++) begin
      tick();
      if (pwm_out !== 1'b0) ones++;
    end
    total++; if (ones !== 0) begin bad++; $display("FAIL sat_pwm_zero got=%0d exp=0", ones); end
  endtask

  task automatic test_pwm_timing();
    int h0, h1;
    for (int c = 0; c < 3 * PRESS_LEN; c++) begin
      btn_up = (c % PRESS_LEN) < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pwm_setup cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd3) begin bad++; $display("FAIL pwm_level3 got=%0d exp=3", indicadorCoriente); end
    for (int k = 0; k < PWM_PERIOD && (n % PWM_PERIOD) != 0; k++) tick();
    h0 = 0;
    for (int c = 0; c < PWM_PERIOD; c++) begin
      btn_up = (c % PRESS_LEN) < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pwm_mid cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (pwm_out === 1'b1) h0++;
    end
    btn_up = 1'b0;
    h1 = 0;
    for (int c = 0; c < PWM_PERIOD; c++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pwm_next cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (pwm_out === 1'b1) h1++;
    end
    total++; if (h0 !== 6) begin bad++; $display("FAIL pwm_period_old got=%0d exp=6", h0); end
    total++; if (h1 !== 10) begin bad++; $display("FAIL pwm_period_new got=%0d exp=10", h1); end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < PRESS_LEN; c++) begin
      btn_down = c < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL simul_prep cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd4) begin bad++; $display("FAIL simul_level4 got=%0d exp=4", indicadorCoriente); end
    for (int c = 0; c < 2 * PRESS_LEN; c++) begin
      btn_up   = (c % PRESS_LEN) < PRESS_HIGH;
      btn_down = (c % PRESS_LEN) < PRESS_HIGH;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL simul cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd4) begin bad++; $display("FAIL simul_hold got=%0d exp=4", indicadorCoriente); end
  endtask

  task automatic test_scan();
    int slot3_cnt, slot3_bcd;
    dig3 = 4'd1; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL scan_fill cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    slot3_cnt = 0; slot3_bcd = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL scan cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (an_n === 4'b0111) begin slot3_cnt++; slot3_bcd += int'(digito_bcd); end
    end
    total++; if (slot3_cnt !== 3) begin bad++; $display("FAIL scan_slot3_len got=%0d exp=3", slot3_cnt); end
    total++; if (slot3_bcd !== 3) begin bad++; $display("FAIL scan_slot3_bcd got=%0d exp=3", slot3_bcd); end
    dig3 = 4'd0;
    for (int c = 0; c < 12; c++) tick();
    slot3_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL scan_zero cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (an_n === 4'b0111) slot3_cnt++;
    end
`ifdef BLANK_ZEROS_EN
    total++; if (slot3_cnt !== 0) begin bad++; $display("FAIL scan_blank got=%0d exp=0", slot3_cnt); end
`else
    total++; if (slot3_cnt !== 3) begin bad++; $display("FAIL scan_noblank got=%0d exp=3", slot3_cnt); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
      if (c % 7 == 0) begin
        dig3 = 4'($urandom_range(0, 9)); dig2 = 4'($urandom_range(0, 9));
        dig1 = 4'($urandom_range(0, 9)); dig0 = 4'($urandom_range(0, 9));
      end
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    btn_up = 1'b0; btn_down = 1'b0;
    for (int c = 0; c < 15; c++) tick();
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 12 && m_level != 7; p++) begin
      for (int c = 0; c < PRESS_LEN; c++) begin
        if (c == 0 && m_level < 7) btn_up = 1'b1;
        if (c == 0 && m_level > 7) btn_down = 1'b1;
        if (c == PRESS_HIGH) begin btn_up = 1'b0; btn_down = 1'b0; end
        tick();
        total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rst_prep cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      end
    end
    total++; if (indicadorCoriente !== 4'd7) begin bad++; $display("FAIL rst_level7 got=%0d exp=7", indicadorCoriente); end
    for (int k = 0; k < PWM_PERIOD && (n % PWM_PERIOD) != 0; k++) tick();
    for (int c = 0; c < 3; c++) tick();
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL rst_pwm_before got=%b exp=1", pwm_out); end
    btn_up = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL rst_pwm got=%b exp=0", pwm_out); end
    total++; if (indicadorCoriente !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", indicadorCoriente); end
    total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b exp=1111", an_n); end
    total++; if (digito_bcd !== 4'd0) begin bad++; $display("FAIL rst_dig got=%0d exp=0", digito_bcd); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 10) btn_up = 1'b0;
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rst_resume cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    total++; if (indicadorCoriente !== 4'd1) begin bad++; $display("FAIL rst_held_press got=%0d exp=1", indicadorCoriente); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_saturation();
    test_pwm_timing();
    test_simultaneous();
    test_scan();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
